// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the mem_valid/mem_ready bus.
// Register window: TXDATA (+0x0, write pushes a byte), STATUS (+0x4, read-only),
// DIV (+0x8, clock cycles per bit). The bytes wait in a TX FIFO, and a
// serializer FSM shifts them out on tx.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | line high, waiting for the FIFO to hold a byte
// START  | start bit (tx=0) for div cycles
// DATA   | 8 data bits, LSB first, div cycles each
// STOP   | stop bit (tx=1) for div cycles, then next frame or IDLE
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          SYSTEM_CLK_HZ = 50_000_000,
  parameter int          BAUD          = 115200,
  parameter int          FIFO_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [15:0]     DIV_RST = 16'(SYSTEM_CLK_HZ / BAUD);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q;
  logic          ready_q, ready_d;
  logic [15:0]   div_q, div_lat_q, cnt_q, div_eff;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic          tx_q, irq_q;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          sel, is_txdata, is_status, is_div;
  logic          fifo_full, fifo_empty, stall, push, pop, busy;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign is_txdata = (mem_addr[3:2] == 2'b00);
  assign is_status = (mem_addr[3:2] == 2'b01);
  assign is_div    = (mem_addr[3:2] == 2'b10);
  assign sel       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && (mem_addr[3:2] != 2'b11);

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != S_IDLE);
  assign div_eff    = (div_q == 16'd0) ? 16'd1 : div_q;

  // A TXDATA write into a full FIFO is held off until the serializer frees a slot.
  assign stall   = sel && is_txdata && mem_wstrb[0] && fifo_full;
  assign ready_d = sel && !ready_q && !stall;
  assign push    = ready_q && sel && is_txdata && mem_wstrb[0];
  assign pop     = !fifo_empty && ((state_q == S_IDLE) || (state_q == S_STOP && cnt_q == 16'd0));

  assign mem_ready = ready_q;
  assign tx        = tx_q;
  assign irq       = irq_q;

  assign unused_bits = ^{mem_addr[1:0], mem_wstrb[3:2], mem_wdata[31:16], is_status};

  // Read mux; data is only driven during the ready cycle.
  always_comb begin
    rd_word = 32'h0;
    case (mem_addr[3:2])
      2'b01:   rd_word = {16'h0, 8'(count_q), 5'h0, busy, fifo_empty, fifo_full};
      2'b10:   rd_word = {16'h0, div_q};
      default: rd_word = 32'h0;
    endcase
    mem_rdata = ready_q ? rd_word : 32'h0;
  end

  // Bus handshake and the DIV register (byte-strobed).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      div_q   <= DIV_RST;
    end else begin
      ready_q <= ready_d;
      if (ready_q && sel && is_div) begin
        if (mem_wstrb[0]) div_q[7:0]  <= mem_wdata[7:0];
        if (mem_wstrb[1]) div_q[15:8] <= mem_wdata[15:8];
      end
    end
  end

  // FIFO storage; contents need no reset because count governs validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Serializer FSM with registered tx and irq; divider latched per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      div_lat_q <= DIV_RST;
      shift_q   <= 8'h00;
      bit_q     <= 3'd0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b1;
    end else begin
      irq_q <= fifo_empty && (state_q == S_IDLE);
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q   <= fifo_mem[rd_ptr_q];
            div_lat_q <= div_eff;
            cnt_q     <= div_eff - 16'd1;
            tx_q      <= 1'b0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == 16'd0) begin
            cnt_q   <= div_lat_q - 16'd1;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 16'd0) begin
            cnt_q <= div_lat_q - 16'd1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == 16'd0) begin
            if (pop) begin
              shift_q   <= fifo_mem[rd_ptr_q];
              div_lat_q <= div_eff;
              cnt_q     <= div_eff - 16'd1;
              tx_q      <= 1'b0;
              state_q   <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and randomized bench for mmio_uart_tx. A line
// receiver decodes tx into bytes, which are compared with the bytes written.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_DIV = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        tx, irq;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mmio_uart_tx dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: decodes frames from tx at the currently programmed rate.
  int         mon_div = 434;
  logic [7:0] rxq[$];
  bit         okq[$];
  int         startq[$];
  logic [7:0] expq[$];

  always begin : rx_mon
    int d;
    bit ok;
    logic [7:0] b;
    @(negedge clk);
    if (reset === 1'b0 && tx === 1'b0) begin
      d = mon_div;
      ok = 1'b1;
      b = 8'h00;
      startq.push_back(cyc);
      repeat (d / 2) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (d) @(negedge clk);
        b[i] = tx;
      end
      repeat (d) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
      rxq.push_back(b);
      okq.push_back(ok);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input bit f, input bit e, input bit b, input int c);
    return {16'h0, 8'(c), 5'h0, b, e, f};
  endfunction

  // One bus access; called at a negedge. Holds the request through the ready cycle.
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                     input int limit, output logic [31:0] rd, output int lat, output bit got);
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = s; mem_wdata = wd;
    got = 1'b0; lat = 0; rd = 32'h0;
    while (!got && lat < limit) begin
      @(negedge clk);
      lat++;
      if (mem_ready === 1'b1) begin
        got = 1'b1;
        rd = mem_rdata;
      end
    end
    if (got) begin
      @(negedge clk);
      chk("ready_pulse", {31'h0, mem_ready}, 32'h0);
    end
    mem_valid = 1'b0; mem_addr = 32'h0; mem_wstrb = 4'h0; mem_wdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
    logic [31:0] rd; int lat; bit got;
    bus(a, s, wd, 100, rd, lat, got);
    chk("wr_latency", 32'(lat), 32'd1);
  endtask

  task automatic bus_rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    logic [31:0] rd; int lat; bit got;
    bus(a, 4'h0, 32'h0, 100, rd, lat, got);
    chk("rd_latency", 32'(lat), 32'd1);
    chk(tag, rd, exp);
  endtask

  task automatic send(input logic [7:0] b);
    bus_wr(A_TX, 4'h1, {24'h0, b});
    expq.push_back(b);
  endtask

  task automatic drain(input int limit);
    int w;
    w = 0;
    while (rxq.size() < expq.size() && w < limit) begin
      @(negedge clk);
      w++;
    end
    chk("rx_count", 32'(rxq.size()), 32'(expq.size()));
    while (expq.size() > 0 && rxq.size() > 0) begin
      chk("rx_byte", {24'h0, rxq.pop_front()}, {24'h0, expq.pop_front()});
      chk("rx_frame", {31'h0, okq.pop_front()}, 32'h1);
    end
    rxq.delete(); okq.delete(); expq.delete();
  endtask

  initial begin
    logic [31:0] rd;
    int lat, w, dr, n;
    bit got;
    logic [7:0] b;

    // Reset state
    @(negedge clk);
    chk("rst_outs", {28'h0, mem_ready, tx, irq, 1'b0}, 32'h6);
    chk("rst_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", {29'h0, mem_ready, tx, irq}, 32'h3);
    end
    bus_rd(A_DIV, "div_reset", 32'd434);

    // Single frame, exact waveform at DIV=4
    bus_wr(A_DIV, 4'h3, 32'd4);
    mon_div = 4;
    b = 8'h55;
    send(b);
    w = 0;
    while (tx !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    chk("start_seen", {31'h0, tx}, 32'h0);
    chk("irq_busy", {31'h0, irq}, 32'h0);
    for (int k = 0; k < 40; k++) begin
      chk("wave_55", {31'h0, tx}, (k < 4) ? 32'h0 : (k < 36) ? {31'h0, b[(k - 4) / 4]} : 32'h1);
      @(negedge clk);
    end
    w = 0;
    while (irq !== 1'b1 && w < 5) begin @(negedge clk); w++; end
    chk("irq_idle", {31'h0, irq}, 32'h1);
    drain(200);

    // Back-to-back frames at DIV=2
    bus_wr(A_DIV, 4'h3, 32'd2);
    mon_div = 2;
    startq.delete();
    send(8'hA5);
    send(8'h3C);
    bus_rd(A_ST, "st_two_q", stat(0, 0, 1, 1));
    w = 0;
    while (startq.size() < 2 && w < 200) begin @(negedge clk); w++; end
    chk("b2b_starts", 32'(startq.size()), 32'd2);
    if (startq.size() >= 2) chk("b2b_gap", 32'(startq[1] - startq[0]), 32'd20);
    bus_rd(A_ST, "st_last", stat(0, 1, 1, 0));
    w = 0;
    while (irq !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    bus_rd(A_ST, "st_idle", stat(0, 1, 0, 0));
    drain(200);

    // Partial-strobe DIV write and STATUS write without effect
    bus_wr(A_DIV, 4'h1, 32'h0000_ABCD);
    bus_rd(A_DIV, "div_strobe", 32'h0000_00CD);
    bus_wr(A_ST, 4'hF, 32'hFFFF_FFFF);
    bus_rd(A_ST, "st_ro", stat(0, 1, 0, 0));

    // Randomized rates (including 0, used as 1) and bytes
    for (int r = 0; r < 4; r++) begin
      dr = (r == 0) ? 0 : $urandom_range(1, 6);
      bus_wr(A_DIV, 4'h3, 32'(dr));
      mon_div = (dr == 0) ? 1 : dr;
      bus_rd(A_DIV, "div_rand", 32'(dr));
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) send(8'($urandom_range(0, 255)));
      drain(2000);
    end

    // Fill the FIFO at DIV=100, then a write that must stall
    bus_wr(A_DIV, 4'h3, 32'd100);
    mon_div = 100;
    startq.delete();
    for (int i = 0; i < 17; i++) send(8'($urandom_range(0, 255)));
    bus_rd(A_ST, "st_full", stat(1, 0, 1, 16));
    b = 8'($urandom_range(0, 255));
    bus(A_TX, 4'h1, {24'h0, b}, 2000, rd, lat, got);
    expq.push_back(b);
    chk("stall_done", {31'h0, got}, 32'h1);
    chk("stall_long", {31'h0, lat > 100}, 32'h1);
    chk("stall_release", 32'(startq.size()), 32'd2);
    bus_rd(A_ST, "st_refull", stat(1, 0, 1, 16));
    drain(20000);

    // Out-of-window and reserved addresses never respond
    bus(32'h1000_000C, 4'h0, 32'h0, 50, rd, lat, got);
    chk("no_ready_c", {31'h0, got}, 32'h0);
    chk("no_rdata_c", mem_rdata, 32'h0);
    bus(32'h2000_0000, 4'hF, 32'h0000_0077, 50, rd, lat, got);
    chk("no_ready_far", {31'h0, got}, 32'h0);
    bus_rd(A_ST, "st_noside", stat(0, 1, 0, 0));

    // Reset during a frame with bytes queued
    bus_wr(A_DIV, 4'h3, 32'd8);
    mon_div = 8;
    startq.delete();
    bus_wr(A_TX, 4'h1, 32'hFF);
    bus_wr(A_TX, 4'h1, 32'h11);
    bus_wr(A_TX, 4'h1, 32'h22);
    bus_wr(A_TX, 4'h1, 32'h33);
    w = 0;
    while (startq.size() < 1 && w < 100) begin @(negedge clk); w++; end
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_async", {30'h0, tx, irq}, 32'h3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    rxq.delete(); okq.delete(); startq.delete(); expq.delete();
    mon_div = 434;
    bus_rd(A_ST, "st_after_rst", stat(0, 1, 0, 0));
    bus_rd(A_DIV, "div_after_rst", 32'd434);
    repeat (200) @(negedge clk);
    chk("no_frames", 32'(startq.size()), 32'd0);
    chk("tx_idle", {31'h0, tx}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
